// File: rtl/game_sequencer.sv
// game_sequencer: 2048 game flow controller; spawns tiles, issues moves, tracks score and status.
// Optional feature: define WIN_DETECT_EN to enable winning-tile detection (game_won / WON state).
module game_sequencer #(
  parameter int N       = 4,
  parameter int CELL_W  = 4,
  parameter int SCORE_W = 16,
  parameter int WIN_EXP = 11,
  parameter int LOC_W   = $clog2(N*N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            btn,
  output logic                  rnd_req,
  input  logic                  rnd_valid,
  input  logic [LOC_W-1:0]      rnd_loc,
  input  logic                  rnd_four,
  input  logic [N*N*CELL_W-1:0] board_cells,
  output logic                  preset_valid,
  output logic [LOC_W-1:0]      preset_loc,
  output logic [CELL_W-1:0]     preset_exp,
  output logic [3:0]            move_dir,
  input  logic                  move_done,
  input  logic                  movable,
  input  logic                  merge_valid,
  input  logic [CELL_W-1:0]     merge_exp,
  output logic [SCORE_W-1:0]    score,
  output logic                  game_over,
  output logic                  game_won
);

  localparam int Cells  = N * N;
  localparam int BoardW = Cells * CELL_W;

  typedef enum logic [2:0] {
    StIdle, StSpawnReq, StSpawnWait, StWaitPress, StMovePend, StCheck, StEnded, StWon
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          spawn_cnt_q, spawn_cnt_d;
  logic [3:0]          btn_s1_q, btn_s2_q, btn_prev_q;
  logic [3:0]          press;
  logic                preset_valid_q, preset_valid_d;
  logic [LOC_W-1:0]    preset_loc_q, preset_loc_d;
  logic [CELL_W-1:0]   preset_exp_q, preset_exp_d;
  logic [3:0]          move_dir_q, move_dir_d;
  logic [BoardW-1:0]   snap_q, snap_d;
  logic                over_q, over_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  addend;
  logic [SCORE_W:0]    score_sum;
  logic                has_empty;
  logic                loc_empty;
`ifdef WIN_DETECT_EN
  logic                won_q, won_d;
  logic                win_cell;
`endif

  assign press = btn_s2_q & ~btn_prev_q;

  // Board scans: any empty cell, and whether the offered random cell is a valid empty target.
  always_comb begin
    has_empty = 1'b0;
    loc_empty = 1'b0;
    for (int i = 0; i < Cells; i++) begin
      if (board_cells[i*CELL_W +: CELL_W] == '0) begin
        has_empty = 1'b1;
        if (rnd_loc == LOC_W'(i)) loc_empty = 1'b1;
      end
    end
  end

`ifdef WIN_DETECT_EN
  always_comb begin
    win_cell = 1'b0;
    for (int i = 0; i < Cells; i++) begin
      if (int'(board_cells[i*CELL_W +: CELL_W]) >= WIN_EXP) win_cell = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d        = state_q;
    spawn_cnt_d    = spawn_cnt_q;
    preset_valid_d = 1'b0;
    preset_loc_d   = preset_loc_q;
    preset_exp_d   = preset_exp_q;
    move_dir_d     = move_dir_q;
    snap_d         = snap_q;
    over_d         = over_q;
    rnd_req        = 1'b0;
`ifdef WIN_DETECT_EN
    won_d          = won_q;
`endif
    unique case (state_q)
      StIdle: begin
        spawn_cnt_d = 2'd2;
        state_d     = StSpawnReq;
      end
      StSpawnReq: begin
        if (!has_empty) begin
          state_d = StCheck;
        end else begin
          rnd_req = 1'b1;
          state_d = StSpawnWait;
        end
      end
      StSpawnWait: begin
        // The preset cycle is spent here so the board has absorbed the write before the next scan.
        if (preset_valid_q) begin
          state_d = (spawn_cnt_q != 2'd0) ? StSpawnReq : StWaitPress;
        end else if (rnd_valid) begin
          if (loc_empty) begin
            preset_valid_d = 1'b1;
            preset_loc_d   = rnd_loc;
            preset_exp_d   = rnd_four ? CELL_W'(2) : CELL_W'(1);
            spawn_cnt_d    = spawn_cnt_q - 2'd1;
          end else begin
            state_d = StSpawnReq;
          end
        end
      end
      StWaitPress: begin
        if (press != 4'b0000) begin
          if (press[0])      move_dir_d = 4'b0001;
          else if (press[1]) move_dir_d = 4'b0010;
          else if (press[2]) move_dir_d = 4'b0100;
          else               move_dir_d = 4'b1000;
          snap_d  = board_cells;
          state_d = StMovePend;
        end
      end
      StMovePend: begin
        if (move_done) begin
          move_dir_d = 4'b0000;
          if (board_cells == snap_q) begin
            state_d = StWaitPress;
          end else
`ifdef WIN_DETECT_EN
          if (win_cell) begin
            state_d = StCheck;
          end else
`endif
          begin
            spawn_cnt_d = 2'd1;
            state_d     = StSpawnReq;
          end
        end
      end
      StCheck: begin
`ifdef WIN_DETECT_EN
        if (win_cell) begin
          won_d   = 1'b1;
          state_d = StWon;
        end else
`endif
        if (movable) begin
          state_d = StWaitPress;
        end else begin
          over_d  = 1'b1;
          state_d = StEnded;
        end
      end
      StEnded: state_d = StEnded;
      StWon:   state_d = StWon;
      default: state_d = StIdle;
    endcase
  end

  // Saturating score; an exponent beyond the score width saturates outright.
  always_comb begin
    addend    = SCORE_W'(1) << merge_exp;
    score_sum = {1'b0, score_q} + {1'b0, addend};
    score_d   = score_q;
    if (merge_valid) begin
      if (int'(merge_exp) >= SCORE_W || score_sum[SCORE_W]) begin
        score_d = '1;
      end else begin
        score_d = score_sum[SCORE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      spawn_cnt_q    <= 2'd0;
      btn_s1_q       <= 4'b0000;
      btn_s2_q       <= 4'b0000;
      btn_prev_q     <= 4'b0000;
      preset_valid_q <= 1'b0;
      preset_loc_q   <= '0;
      preset_exp_q   <= '0;
      move_dir_q     <= 4'b0000;
      snap_q         <= '0;
      over_q         <= 1'b0;
      score_q        <= '0;
    end else begin
      state_q        <= state_d;
      spawn_cnt_q    <= spawn_cnt_d;
      btn_s1_q       <= btn;
      btn_s2_q       <= btn_s1_q;
      btn_prev_q     <= btn_s2_q;
      preset_valid_q <= preset_valid_d;
      preset_loc_q   <= preset_loc_d;
      preset_exp_q   <= preset_exp_d;
      move_dir_q     <= move_dir_d;
      snap_q         <= snap_d;
      over_q         <= over_d;
      score_q        <= score_d;
    end
  end

`ifdef WIN_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) won_q <= 1'b0;
    else     won_q <= won_d;
  end
  assign game_won = won_q;
`else
  assign game_won = 1'b0;
`endif

  assign preset_valid = preset_valid_q;
  assign preset_loc   = preset_loc_q;
  assign preset_exp   = preset_exp_q;
  assign move_dir     = move_dir_q;
  assign score        = score_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: the bench plays board, random source and player,
// and predicts strobes, move requests, score and status from the game rules.
module tb_game_sequencer;

  localparam int N       = 4;
  localparam int CELL_W  = 4;
  localparam int SCORE_W = 16;
  localparam int WIN_EXP = 11;
  localparam int LOC_W   = 4;
  localparam int CELLS   = N * N;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [3:0]              btn;
  logic                    rnd_req;
  logic                    rnd_valid;
  logic [LOC_W-1:0]        rnd_loc;
  logic                    rnd_four;
  logic [CELLS*CELL_W-1:0] board_cells;
  logic                    preset_valid;
  logic [LOC_W-1:0]        preset_loc;
  logic [CELL_W-1:0]       preset_exp;
  logic [3:0]              move_dir;
  logic                    move_done;
  logic                    movable;
  logic                    merge_valid;
  logic [CELL_W-1:0]       merge_exp;
  logic [SCORE_W-1:0]      score;
  logic                    game_over;
  logic                    game_won;

  int n_tests = 0;
  int n_fail  = 0;
  int score_m;
  logic [CELL_W-1:0] board_m [CELLS];

  game_sequencer #(
    .N       (N),
    .CELL_W  (CELL_W),
    .SCORE_W (SCORE_W),
    .WIN_EXP (WIN_EXP),
    .LOC_W   (LOC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .rnd_req      (rnd_req),
    .rnd_valid    (rnd_valid),
    .rnd_loc      (rnd_loc),
    .rnd_four     (rnd_four),
    .board_cells  (board_cells),
    .preset_valid (preset_valid),
    .preset_loc   (preset_loc),
    .preset_exp   (preset_exp),
    .move_dir     (move_dir),
    .move_done    (move_done),
    .movable      (movable),
    .merge_valid  (merge_valid),
    .merge_exp    (merge_exp),
    .score        (score),
    .game_over    (game_over),
    .game_won     (game_won)
  );

  always #5 clk = ~clk;

  always_comb begin
    board_cells = '0;
    for (int i = 0; i < CELLS; i++) board_cells[i*CELL_W +: CELL_W] = board_m[i];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Up is bit 0 and has top priority, so the lowest set bit wins.
  function automatic logic [3:0] pick_dir(input logic [3:0] b);
    return b & (~b + 4'd1);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    btn = 4'b0; rnd_valid = 1'b0; rnd_loc = '0; rnd_four = 1'b0;
    move_done = 1'b0; movable = 1'b1; merge_valid = 1'b0; merge_exp = '0;
    for (int i = 0; i < CELLS; i++) board_m[i] = '0;
    score_m = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Answer one random request; the board model decides whether a preset must follow.
  task automatic spawn_step(input int loc, input bit four, input bit wait_req, output bit hit);
    bit seen;
    int want_exp;
    hit = 1'b0;
    if (wait_req) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (rnd_req) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check_eq("rnd_req_seen", 64'(seen), 64'd1);
      if (!seen) return;
      @(negedge clk);
      check_eq("rnd_req_one_cycle", 64'(rnd_req), 64'd0);
    end
    rnd_valid = 1'b1; rnd_loc = LOC_W'(loc); rnd_four = four;
    @(negedge clk);
    rnd_valid = 1'b0;
    hit = (loc < CELLS) && (board_m[loc] == '0);
    want_exp = four ? 2 : 1;
    check_eq("preset_valid", 64'(preset_valid), 64'(hit));
    if (hit) begin
      check_eq("preset_loc", 64'(preset_loc), 64'(loc));
      check_eq("preset_exp", 64'(preset_exp), 64'(want_exp));
      check_eq("no_req_in_preset", 64'(rnd_req), 64'd0);
      board_m[loc] = CELL_W'(want_exp);
      @(negedge clk);
      check_eq("preset_one_cycle", 64'(preset_valid), 64'd0);
    end else begin
      check_eq("retry_req", 64'(rnd_req), 64'd1);
    end
  endtask

  task automatic press_btn(input logic [3:0] b, input logic [3:0] want, input string tag);
    btn = b;
    repeat (3) @(negedge clk);
    check_eq(tag, 64'(move_dir), 64'(want));
    btn = 4'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic done_pulse(input string tag);
    move_done = 1'b1;
    @(negedge clk);
    move_done = 1'b0;
    check_eq(tag, 64'(move_dir), 64'd0);
  endtask

  task automatic quiet(input int n, input string tag);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (rnd_req) cnt++;
    end
    check_eq(tag, 64'(cnt), 64'd0);
  endtask

  task automatic merge(input int e, input bit v, input string tag);
    merge_valid = v; merge_exp = CELL_W'(e);
    @(negedge clk);
    merge_valid = 1'b0;
    if (v) begin
      score_m = score_m + (1 << e);
      if (score_m > 65535) score_m = 65535;
    end
    check_eq(tag, 64'(score), 64'(score_m));
  endtask

  initial begin
    bit hit;
    int presets;
    rst = 1'b1;
    btn = 4'b0; rnd_valid = 1'b0; rnd_loc = '0; rnd_four = 1'b0;
    move_done = 1'b0; movable = 1'b1; merge_valid = 1'b0; merge_exp = '0;
    for (int i = 0; i < CELLS; i++) board_m[i] = '0;
    score_m = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_score", 64'(score), 64'd0);
    check_eq("rst_rnd_req", 64'(rnd_req), 64'd0);
    check_eq("rst_preset_valid", 64'(preset_valid), 64'd0);
    check_eq("rst_preset_loc", 64'(preset_loc), 64'd0);
    check_eq("rst_preset_exp", 64'(preset_exp), 64'd0);
    check_eq("rst_move_dir", 64'(move_dir), 64'd0);
    check_eq("rst_game_over", 64'(game_over), 64'd0);
    check_eq("rst_game_won", 64'(game_won), 64'd0);

    // Reset release: one idle cycle, then two spawns at 5 and 9.
    rst = 1'b0;
    check_eq("idle_no_req", 64'(rnd_req), 64'd0);
    @(negedge clk);
    check_eq("idle_to_spawn", 64'(rnd_req), 64'd1);
    spawn_step(5, 1'b0, 1'b1, hit);
    spawn_step(9, 1'b1, 1'b1, hit);
    quiet(6, "wait_press_quiet");
    check_eq("no_move_yet", 64'(move_dir), 64'd0);

    // Up and left together: up wins and is held until move_done.
    press_btn(4'b0101, pick_dir(4'b0101), "dir_up_left");
    repeat (4) begin
      @(negedge clk);
      check_eq("dir_held", 64'(move_dir), 64'd1);
    end
    board_m[1] = board_m[5];
    board_m[5] = '0;
    done_pulse("dir_clear");
    spawn_step(1, 1'b0, 1'b1, hit);
    spawn_step(3, 1'b0, 1'b1, hit);
    quiet(5, "after_move_spawn_quiet");

    // Unchanged board: no spawn, straight back to waiting for a press.
    press_btn(4'b1000, pick_dir(4'b1000), "dir_right");
    done_pulse("dir_clear_nochange");
    quiet(6, "nochange_no_spawn");
    press_btn(4'b0110, pick_dir(4'b0110), "dir_down_left");

    // Reset while a move is pending aborts everything at once.
    rst = 1'b1;
    #1;
    check_eq("abort_move_dir", 64'(move_dir), 64'd0);
    check_eq("abort_rnd_req", 64'(rnd_req), 64'd0);
    check_eq("abort_preset", 64'(preset_valid), 64'd0);
    do_reset();

    // Press while waiting on the random source is discarded; score accumulates meanwhile.
    repeat (3) @(negedge clk);
    btn = 4'b0001;
    repeat (4) @(negedge clk);
    btn = 4'b0000;
    repeat (2) @(negedge clk);
    merge(1, 1'b1, "score_a");
    merge(1, 1'b1, "score_b");
    merge(3, 1'b1, "score_c");
    merge(15, 1'b1, "score_d");
    merge(15, 1'b1, "score_sat");
    spawn_step(2, 1'b0, 1'b0, hit);
    spawn_step(7, 1'b1, 1'b1, hit);
    repeat (4) @(negedge clk);
    check_eq("stale_press_dropped", 64'(move_dir), 64'd0);

    // Randomised spawns on a randomly pre-filled board, then random merges.
    do_reset();
    for (int i = 0; i < CELLS - 2; i++)
      board_m[i] = ($urandom_range(0, 2) == 0) ? CELL_W'($urandom_range(1, 10)) : '0;
    presets = 0;
    for (int k = 0; k < 60 && presets < 2; k++) begin
      spawn_step(int'($urandom_range(0, CELLS - 1)), 1'($urandom_range(0, 1)), 1'b1, hit);
      if (hit) presets++;
    end
    check_eq("rand_presets", 64'(presets), 64'd2);
    for (int k = 0; k < 24; k++)
      merge(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "score_rand");

    // Full board after a move: movable continues play, immovable ends the game for good.
    do_reset();
    spawn_step(0, 1'b0, 1'b1, hit);
    spawn_step(1, 1'b0, 1'b1, hit);
    press_btn(4'b0001, pick_dir(4'b0001), "dir_up_full");
    for (int i = 0; i < CELLS; i++) board_m[i] = CELL_W'((i % 10) + 1);
    movable = 1'b1;
    done_pulse("dir_clear_full");
    quiet(4, "full_no_spawn");
    check_eq("full_not_over", 64'(game_over), 64'd0);
    press_btn(4'b0100, pick_dir(4'b0100), "dir_left_full");
    for (int i = 0; i < CELLS; i++) board_m[i] = CELL_W'(((i + 3) % 10) + 1);
    movable = 1'b0;
    done_pulse("dir_clear_end");
    quiet(4, "end_no_spawn");
    check_eq("game_over", 64'(game_over), 64'd1);
    press_btn(4'b0010, 4'b0000, "ended_ignores_press");
    check_eq("ended_still_over", 64'(game_over), 64'd1);
    check_eq("ended_not_won", 64'(game_won), 64'd0);

    // Winning tile after a move.
    do_reset();
    spawn_step(4, 1'b0, 1'b1, hit);
    spawn_step(6, 1'b0, 1'b1, hit);
    press_btn(4'b0010, pick_dir(4'b0010), "dir_down_win");
    board_m[0] = CELL_W'(WIN_EXP);
    board_m[4] = '0;
    done_pulse("dir_clear_win");
`ifdef WIN_DETECT_EN
    quiet(3, "won_no_spawn");
    check_eq("game_won", 64'(game_won), 64'd1);
    press_btn(4'b1000, 4'b0000, "won_ignores_press");
    check_eq("won_not_over", 64'(game_over), 64'd0);
`else
    spawn_step(15, 1'b0, 1'b1, hit);
    check_eq("win_disabled", 64'(game_won), 64'd0);
    press_btn(4'b1000, pick_dir(4'b1000), "play_continues");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning board side length (cells = N*N, N in 2..8).
REQ-002 The block SHALL have parameter CELL_W, default 4, meaning tile exponent width (0 = empty).
REQ-003 The block SHALL have parameter SCORE_W, default 16, meaning score width.
REQ-004 The block SHALL have parameter WIN_EXP, default 11, meaning winning tile exponent (2048).
REQ-005 The block SHALL have parameter LOC_W, default $clog2(N*N), meaning cell index width.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed in REQ-007 to REQ-023.
REQ-007 The block SHALL have port clk, input, 1, system clock.
REQ-008 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port btn, input, 4, raw buttons {right,left,down,up}.
REQ-010 The block SHALL have port rnd_req, output, 1, request to the random generator.
REQ-011 The block SHALL have port rnd_valid, input, 1, random result valid.
REQ-012 The block SHALL have port rnd_loc, input, LOC_W, random cell index.
REQ-013 The block SHALL have port rnd_four, input, 1, spawn 4 instead of 2.
REQ-014 The block SHALL have port board_cells, input, N*N*CELL_W, cell i at bits [i*CELL_W +: CELL_W].
REQ-015 The block SHALL have port preset_valid, output, 1, one-cycle tile write strobe.
REQ-016 The block SHALL have port preset_loc, output, LOC_W, tile write index.
REQ-017 The block SHALL have port preset_exp, output, CELL_W, tile write exponent.
REQ-018 The block SHALL have port move_dir, output, 4, one-hot move request, held until move_done.
REQ-019 The block SHALL have port move_done, input, 1, board move complete.
REQ-020 The block SHALL have port movable, input, 1, board has a legal move.
REQ-021 The block SHALL have port merge_valid and merge_exp, input, 1 and CELL_W, per-merge report.
REQ-022 The block SHALL have port score, output, SCORE_W, accumulated score.
REQ-023 The block SHALL have port game_over and game_won, output, 1 each, sticky status.

Function
REQ-024 The block SHALL pass btn through a 2-flop synchroniser and then a rising-edge detector, giving press[3:0].
REQ-025 The block SHALL implement states IDLE, SPAWN_REQ, SPAWN_WAIT, WAIT_PRESS, MOVE_PEND, CHECK, ENDED and WON.
REQ-026 IDLE SHALL go to SPAWN_REQ one cycle after reset deasserts, with spawn_cnt=2.
REQ-027 SPAWN_REQ SHALL assert rnd_req for exactly one cycle, then enter SPAWN_WAIT.
REQ-028 In SPAWN_WAIT on rnd_valid with cell rnd_loc empty: pulse preset_valid one cycle later with preset_exp = rnd_four ? 2 : 1, then decrement spawn_cnt.
REQ-029 The block SHALL treat a rnd_loc that is occupied or >= N*N as a miss: return to SPAWN_REQ (retry), with no preset write.
REQ-030 After a preset, spawn_cnt>0 SHALL give SPAWN_REQ; otherwise the block goes to WAIT_PRESS.
REQ-031 A spawn with zero empty cells SHALL skip directly to CHECK.
REQ-032 In WAIT_PRESS a nonzero press SHALL latch move_dir one-hot with priority up>down>left>right and enter MOVE_PEND.
REQ-033 Presses outside WAIT_PRESS SHALL be discarded.
REQ-034 MOVE_PEND SHALL hold move_dir until move_done, then clear move_dir, set spawn_cnt=1 and enter SPAWN_REQ.
REQ-035 A board unchanged by the move (board_cells equal before and after) SHALL return to WAIT_PRESS without a spawn.
REQ-036 CHECK SHALL go to WAIT_PRESS if movable=1, else to ENDED and set game_over.
REQ-037 ENDED and WON SHALL be terminal until reset.
REQ-038 On each merge_valid the block SHALL add 1<<merge_exp to score, saturating at all-ones; merge_valid is honoured in any state.
REQ-039 merge_exp >= SCORE_W SHALL saturate score.

Reset
REQ-040 On reset: state=IDLE, score=0, rnd_req=0, preset_valid=0, preset_loc=0, preset_exp=0, move_dir=0, game_over=0, game_won=0, synchronisers=0.
REQ-041 Reset mid-operation SHALL abort any pending handshake immediately, with no further strobes.

Configuration
REQ-042 With WIN_DETECT_EN defined, any cell reaching WIN_EXP, checked in CHECK before movable, SHALL set game_won and enter WON.
REQ-043 With WIN_DETECT_EN undefined, game_won SHALL be tied 0, WON SHALL be unreachable, and play continues.

Verification
REQ-044 Bench SHALL cover: reset release, random source returns loc 5 then 9 -> two preset strobes at loc 5 and 9, then WAIT_PRESS.
REQ-045 Bench SHALL cover: rnd_loc hits an occupied cell, then loc 3 -> one retry rnd_req, single preset at loc 3.
REQ-046 Bench SHALL cover: btn up and left rise in the same cycle -> move_dir=0001, held until move_done.
REQ-047 Bench SHALL cover: merges with exp 1, 1, then 3 -> score 2, 4, 12; exp 15 then 15 -> score saturates at 0xFFFF.
REQ-048 Bench SHALL cover: move_done with a full board and movable=0 -> ENDED, game_over=1, later presses ignored.
REQ-049 Bench SHALL cover (WIN_DETECT_EN defined): cell value 11 after a move -> game_won=1, state WON; with the macro undefined -> game_won stays 0.
